param_delay_line: RTL and testbench

//  Parametrised sample delay line for the DSP datapath: WIDTH-bit samples, delay selectable at run time (1..DEPTH).

---
 rtl/pdl_pkg.sv | 29 ++
 rtl/pdl_ram.sv | 36 +++
 rtl/param_delay_line.sv | 112 +++++++++++
 tb/tb_param_delay_line.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdl_pkg.sv
// -----------------------------------------------------------------------------
// pdl_pkg
// Shared helpers for the parametrised delay line:
//   dw_of()       width of a port that must carry values 0..depth
//   clamp_delay() maps a requested delay onto the legal range 1..depth
//   ptr_sub()     circular-buffer pointer subtraction, modulo depth, with no
//                 power-of-two assumption on depth
// -----------------------------------------------------------------------------
package pdl_pkg;

  function automatic int dw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int clamp_delay(input int d, input int depth);
    if (d < 1)     return 1;
    if (d > depth) return depth;
    return d;
  endfunction

  // (a - b) mod depth for 0 <= a, b < depth.
  function automatic int ptr_sub(input int a, input int b, input int depth);
    int diff;
    diff = a - b;
    if (diff < 0) diff = diff + depth;
    return diff;
  endfunction

endpackage

// File: rtl/pdl_ram.sv
// -----------------------------------------------------------------------------
// pdl_ram
// WIDTH x DEPTH simple dual-port RAM: synchronous write, asynchronous read.
// A read of the address being written on the same edge returns the old word.
// Ports:
//   clk      in   1      write clock, rising edge
//   i_we     in   1      write enable
//   i_waddr  in   AW     write address
//   i_wdata  in   WIDTH  write data
//   i_raddr  in   AW     read address
//   o_rdata  out  WIDTH  read data (combinational)
// -----------------------------------------------------------------------------
module pdl_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 100,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage array has no reset so it maps onto RAM primitives; history
  // validity is tracked by the fill counter in the parent, not by contents.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/param_delay_line.sv
// -----------------------------------------------------------------------------
// param_delay_line
// Run-time selectable sample delay (1..DEPTH) built on a circular buffer with
// a sample-strobe handshake. Each accepted sample is written at wptr; the
// output register is loaded with the sample d_eff-1 slots behind it (or the
// incoming sample itself when d_eff==1), so after the k-th accepted sample
// out carries sample k-(d_eff-1).
//
// Optional feature macro: PDL_ZERO_FILL_EN
//   defined     : out is forced to 0 on accepting edges where out_valid goes 0
//   not defined : out carries the raw RAM read; qualify with out_valid
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   flush      in   1      synchronous clear of history (wins over in_valid)
//   in_valid   in   1      sample strobe
//   in         in   WIDTH  input sample
//   delay      in   DW     requested delay, clamped to 1..DEPTH
//   out_valid  out  1      out holds a sample fully delayed by d_eff
//   out        out  WIDTH  delayed sample, registered
//   fill       out  DW     samples written since reset/flush, saturating
// -----------------------------------------------------------------------------
module param_delay_line
  import pdl_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 100,
  localparam int DW    = dw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [DW-1:0]    delay,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [DW-1:0]    fill
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [DW-1:0]    r_fill;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;

  logic [DW-1:0]    w_d_eff;
  logic [AW-1:0]    w_rd_addr;
  logic [WIDTH-1:0] w_rd_data;
  logic [DW:0]      w_fill_inc;
  logic             w_new_valid;
  logic [WIDTH-1:0] w_new_out;
  logic             w_we;

  assign w_d_eff    = DW'(clamp_delay(32'(delay), DEPTH));
  // Slot written d_eff-1 samples ago; RAM is read before this edge's write.
  assign w_rd_addr  = AW'(ptr_sub(32'(r_wptr), 32'(w_d_eff) - 1, DEPTH));
  assign w_fill_inc = {1'b0, r_fill} + (DW+1)'(1);
  assign w_new_valid = (w_fill_inc >= {1'b0, w_d_eff});
  // A flushed sample is discarded, so it must not reach the buffer either.
  assign w_we       = in_valid & ~flush;

  // NOTE: every always_comb output gets a default assignment first so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    w_new_out = (w_d_eff == DW'(1)) ? in : w_rd_data;
`ifdef PDL_ZERO_FILL_EN
    if (!w_new_valid) w_new_out = '0;
`endif
  end

  pdl_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (in),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_fill      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_fill      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_wptr      <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (r_fill != DW'(DEPTH)) r_fill <= r_fill + 1'b1;
      r_out       <= w_new_out;
      r_out_valid <= w_new_valid;
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign fill      = r_fill;

endmodule

// File: tb/tb_param_delay_line.sv
module tb_param_delay_line;

  localparam int WIDTH = 32;
  localparam int DEPTH = 100;
  localparam int DW    = $clog2(DEPTH + 1);
`ifdef PDL_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_s = '0;
  logic [DW-1:0]    delay = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_s;
  logic [DW-1:0]    fill;

  always #5 clk = ~clk;

  param_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in        (in_s),
    .delay     (delay),
    .out_valid (out_valid),
    .out       (out_s),
    .fill      (fill)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: full history of accepted samples since reset/flush.
  logic [31:0] hist[$];
  bit          m_valid;
  logic [31:0] m_out;
  bit          m_known;
  int          m_fill;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_valid = 1'b0;
    m_out   = '0;
    m_known = 1'b1;
    m_fill  = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input int dl, input bit fl);
    int de;
    int n;
    if (fl) begin
      model_reset();
    end else if (v) begin
      de = (dl < 1) ? 1 : ((dl > DEPTH) ? DEPTH : dl);
      hist.push_back(d);
      n = hist.size();
      m_fill  = (n > DEPTH) ? DEPTH : n;
      m_valid = (n >= de);
      if (m_valid) begin
        m_out   = hist[n - de];
        m_known = 1'b1;
      end else if (ZF) begin
        m_out   = '0;
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, "_fill"},  32'(fill),      32'(m_fill));
    if (m_known) check({tag, "_out"}, out_s, m_out);
  endtask

  task automatic apply(input bit v, input logic [31:0] d, input int dl, input bit fl);
    @(negedge clk);
    in_valid = v;
    in_s     = d;
    delay    = DW'(dl);
    flush    = fl;
    @(posedge clk);
    model_edge(v, d, dl, fl);
    #1;
  endtask

  // Reset asserted away from any clock edge; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rst_out"},   out_s,          32'd0);
    check({tag, "_rst_fill"},  32'(fill),      32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    logic [31:0] din;
    int          dl;
    bit          fl;
    bit          e_valid;
    logic [31:0] e_out;
    int          e_fill;
    bit          chk_out;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 32'hA5A5A5A5, 1,   1'b0, 1'b1, 32'hA5A5A5A5, 1, 1'b1};
    tbl[1] = '{1'b0, 32'h00000000, 1,   1'b0, 1'b1, 32'hA5A5A5A5, 1, 1'b1};
    tbl[2] = '{1'b1, 32'h00000011, 0,   1'b0, 1'b1, 32'h00000011, 2, 1'b1};
    tbl[3] = '{1'b1, 32'h00000022, 2,   1'b0, 1'b1, 32'h00000011, 3, 1'b1};
    tbl[4] = '{1'b1, 32'h00000033, 3,   1'b0, 1'b1, 32'h00000011, 4, 1'b1};
    tbl[5] = '{1'b1, 32'h00000044, 127, 1'b0, 1'b0, 32'h00000000, 5, ZF};
    tbl[6] = '{1'b1, 32'h00000055, 1,   1'b1, 1'b0, 32'h00000000, 0, 1'b1};
    tbl[7] = '{1'b1, 32'h00000066, 1,   1'b0, 1'b1, 32'h00000066, 1, 1'b1};

    model_reset();
    repeat (2) @(posedge clk);
    do_reset("init");

    // Short vectors: delay=1 register, clamping of 0 and >DEPTH, flush.
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i].v, tbl[i].din, tbl[i].dl, tbl[i].fl);
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_fill", i),  32'(fill),      32'(tbl[i].e_fill));
      if (tbl[i].chk_out) check($sformatf("tbl%0d_out", i), out_s, tbl[i].e_out);
    end

    // Maximum delay, continuous strobe: behaves as a DEPTH-stage chain.
    do_reset("t1");
    for (int k = 1; k <= 250; k++) begin
      apply(1'b1, 32'(k), DEPTH, 1'b0);
      check_model($sformatf("t1_k%0d", k));
      if (k == 99)  check("t1_valid_at_99", 32'(out_valid), 32'd0);
      if (k == 100) check("t1_out_at_100", out_s, 32'd1);
      if (k == 250) check("t1_out_at_250", out_s, 32'd151);
    end

    // Gapped strobe, delay 5: state moves only on strobe edges.
    do_reset("t4");
    begin
      int k;
      k = 0;
      for (int c = 0; c < 30; c++) begin
        bit v;
        v = (c % 3 == 0);
        if (v) k++;
        apply(v, 32'(k), 5, 1'b0);
        check_model($sformatf("t4_c%0d", c));
      end
      check("t4_final_out", out_s, 32'(k - 4));
    end

    // Delay increase after saturation, then async reset mid-stream.
    do_reset("t5");
    for (int k = 1; k <= 150; k++) begin
      apply(1'b1, 32'(k), 10, 1'b0);
      check_model($sformatf("t5_k%0d", k));
    end
    apply(1'b1, 32'd151, 40, 1'b0);
    check("t5_switch_valid", 32'(out_valid), 32'd1);
    check("t5_switch_out", out_s, 32'd112);
    do_reset("t5_mid");

    // Flush colliding with a strobe at fill=50, then refill.
    for (int k = 1; k <= 50; k++) apply(1'b1, 32'(k), 10, 1'b0);
    check("t6_fill50", 32'(fill), 32'd50);
    apply(1'b1, 32'd51, 10, 1'b1);
    check("t6_flush_fill", 32'(fill), 32'd0);
    check("t6_flush_valid", 32'(out_valid), 32'd0);
    check("t6_flush_out", out_s, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      apply(1'b1, 32'(1000 + k), 10, 1'b0);
      check_model($sformatf("t6_k%0d", k));
    end

    // Randomized traffic against the history model.
    do_reset("rnd");
    begin
      int dl;
      dl = 7;
      for (int c = 0; c < 3000; c++) begin
        bit v;
        bit fl;
        if ($urandom_range(0, 49) == 0) dl = int'($urandom_range(0, 127));
        v  = ($urandom_range(0, 9) < 7);
        fl = ($urandom_range(0, 299) == 0);
        apply(v, $urandom, dl, fl);
        check_model($sformatf("rnd_c%0d", c));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
